// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register-file hazard scheduler between issue and writeback.
//
// Each GPR x1..x31 has a pending-write counter. An instruction is held off
// while any register it reads or writes has an outstanding write. A commit
// from the writeback unit releases one reservation. A flush discards all
// reservations.
//
// Optional feature: define RF_SCOREBOARD_BYPASS_EN to let a source or rd
// hazard clear in the same cycle that the last pending write to that
// register commits. This matches the writeback forwarding path.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   iss_*                issue-stage instruction (valid, rs1/rs2 reads, rd write)
//   iss_ready_o          instruction may issue this cycle (combinational)
//   wb_valid_i/_rd_we_i  writeback commit of rd index wb_rd_i
//   flush_i              drop all outstanding reservations
//   inflight_o, busy_o   total outstanding reservations, and nonzero flag
//   err_o                sticky: commit to a register with nothing pending
module rf_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       iss_valid_i,
  input  logic       iss_rs1_en_i,
  input  logic [4:0] iss_rs1_i,
  input  logic       iss_rs2_en_i,
  input  logic [4:0] iss_rs2_i,
  input  logic       iss_rd_we_i,
  input  logic [4:0] iss_rd_i,
  output logic       iss_ready_o,
  input  logic       wb_valid_i,
  input  logic       wb_rd_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic       flush_i,
  output logic [5:0] inflight_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [5:0]       TotMax = 6'(MAX_INFLIGHT);

  // Entry 0 exists only to keep indexing simple; it is never written.
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [5:0]       total_q, total_d;
  logic             err_q, err_d;

  logic commit_fire, commit_ok, issue_fire;
  logic rs1_byp, rs2_byp, rd_byp;
  logic hazard, full;

  always_comb begin
    commit_fire = wb_valid_i && wb_rd_we_i && (wb_rd_i != 5'd0);
    commit_ok   = commit_fire && (cnt_q[wb_rd_i] != '0);

`ifdef RF_SCOREBOARD_BYPASS_EN
    // Last pending write retiring this cycle: value arrives via forwarding.
    rs1_byp = commit_fire && (wb_rd_i == iss_rs1_i) && (cnt_q[iss_rs1_i] == CntOne);
    rs2_byp = commit_fire && (wb_rd_i == iss_rs2_i) && (cnt_q[iss_rs2_i] == CntOne);
    rd_byp  = commit_fire && (wb_rd_i == iss_rd_i)  && (cnt_q[iss_rd_i]  == CntOne);
`else
    rs1_byp = 1'b0;
    rs2_byp = 1'b0;
    rd_byp  = 1'b0;
`endif

    hazard = (iss_rs1_en_i && (iss_rs1_i != 5'd0) && (cnt_q[iss_rs1_i] != '0) && !rs1_byp) ||
             (iss_rs2_en_i && (iss_rs2_i != 5'd0) && (cnt_q[iss_rs2_i] != '0) && !rs2_byp) ||
             (iss_rd_we_i  && (iss_rd_i  != 5'd0) && (cnt_q[iss_rd_i]  != '0) && !rd_byp);

    full = iss_rd_we_i && (iss_rd_i != 5'd0) &&
           ((total_q == TotMax) || (cnt_q[iss_rd_i] == CntMax));

    iss_ready_o = !hazard && !full && !flush_i;
    issue_fire  = iss_valid_i && iss_ready_o && iss_rd_we_i && (iss_rd_i != 5'd0);

    // Same-register issue+commit nets to zero through the +1/-1 pair.
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue_fire && (iss_rd_i == 5'(i))) cnt_d[i] = cnt_d[i] + CntOne;
      if (commit_ok  && (wb_rd_i  == 5'(i))) cnt_d[i] = cnt_d[i] - CntOne;
    end

    total_d = total_q;
    if (issue_fire && !commit_ok) begin
      total_d = total_q + 6'd1;
    end else if (!issue_fire && commit_ok) begin
      total_d = total_q - 6'd1;
    end

    err_d = err_q | (commit_fire && !commit_ok);

    // Flush kills everything in flight, including this cycle's commit.
    if (flush_i) begin
      for (int i = 0; i < 32; i++) cnt_d[i] = '0;
      total_d = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      cnt_q[0] <= '0;
      total_q  <= total_d;
      err_q    <= err_d;
    end
  end

  assign inflight_o = total_q;
  assign busy_o     = (total_q != 6'd0);
  assign err_o      = err_q;

endmodule
